mmu_row_sequencer: RTL and testbench

- Control-only sequencer that streams N input rows through the 8x8 matrix multiply unit (MMU) one row at a time against one loaded weight set.
- Per command: loads weights once, then for each row fetches the input row from the row buffer, fires the MMU, and writes the 8-lane result to the result buffer at a sequential address.
- Sits between the command front-end and the MMU/buffer data paths and carries no data itself.

---
 rtl/mmu_row_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_mmu_row_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_row_sequencer.sv
// -----------------------------------------------------------------------------
// mmu_row_sequencer
//
// Control-only sequencer that streams N input rows through the 8x8 MMU against
// one loaded weight set. Per command it loads the weights once, then for each
// row reads the row buffer, fires the MMU, waits for mmu_done and writes the
// result to the result buffer at a sequential address. It carries no data.
//
// Every output is a register loaded with the value that belongs to the state
// being entered, so an output is high exactly in the cycle its state is
// occupied. mmu_clear is the one exception: it is loaded from the command
// handshake and pulses in the first cycle after acceptance.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid / cmd_ready          command handshake (ready only in IDLE)
//   cmd_src_base, cmd_dst_base     first row-read / result-write address
//   cmd_num_rows                   rows to process (0 finishes immediately)
//   abort                          cancel the running command
//   wt_load_req / wt_load_ack      weight-register load handshake
//   rd_req, rd_addr / rd_valid     row read pulse and row-data-present
//   mmu_clear, mmu_start,
//   mmu_input_valid,
//   mmu_weight_valid / mmu_done    MMU control and completion
//   wr_valid, wr_addr / wr_ready   result write handshake
//   busy, done, error, rows_done   status (error is sticky until next command)
//
// TIMEOUT must be at least 1.
// -----------------------------------------------------------------------------
module mmu_row_sequencer #(
    parameter int ADDR_W  = 10,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src_base,
    input  logic [ADDR_W-1:0] cmd_dst_base,
    input  logic [CNT_W-1:0]  cmd_num_rows,
    input  logic              abort,
    output logic              wt_load_req,
    input  logic              wt_load_ack,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_valid,
    output logic              mmu_clear,
    output logic              mmu_start,
    output logic              mmu_input_valid,
    output logic              mmu_weight_valid,
    input  logic              mmu_done,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  rows_done
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WLOAD = 3'd1,
        S_RD    = 3'd2,
        S_RWAIT = 3'd3,
        S_FIRE  = 3'd4,
        S_MWAIT = 3'd5,
        S_WR    = 3'd6,
        S_FIN   = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [CNT_W-1:0]  num_q, num_d;
    // rows_q counts completed writes and doubles as the current row index
    logic [CNT_W-1:0]  rows_q, rows_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              err_q, err_d;
    logic              clear_d;

    logic              cmd_ready_q, busy_q, done_q, mmu_clear_q;
    logic              wt_load_req_q, rd_req_q, wr_valid_q;
    logic              mmu_start_q, mmu_weight_valid_q;
    logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;

    logic [CNT_W-1:0]  rows_inc_s;
    logic [TMO_W-1:0]  tmo_dec_s;
    logic [ADDR_W-1:0] rd_addr_s, wr_addr_s;

    // Helper arithmetic; address sums wrap modulo 2^ADDR_W by truncation
    always_comb begin
        rows_inc_s = rows_q + {{(CNT_W-1){1'b0}}, 1'b1};
        tmo_dec_s  = tmo_q - {{(TMO_W-1){1'b0}}, 1'b1};
        rd_addr_s  = src_d + ADDR_W'(rows_d);
        wr_addr_s  = dst_d + ADDR_W'(rows_d);
    end

    // Next-state logic; abort takes priority over any progress in a busy state
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        num_d   = num_q;
        rows_d  = rows_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        clear_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    src_d   = cmd_src_base;
                    dst_d   = cmd_dst_base;
                    num_d   = cmd_num_rows;
                    rows_d  = {CNT_W{1'b0}};
                    err_d   = 1'b0;
                    clear_d = 1'b1;
                    state_d = (cmd_num_rows == {CNT_W{1'b0}}) ? S_FIN : S_WLOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WLOAD: begin
                if (abort) begin
                    state_d = S_FIN;
                end else if (wt_load_ack) begin
                    state_d = S_RD;
                end else begin
                    state_d = S_WLOAD;
                end
            end
            S_RD: begin
                state_d = abort ? S_FIN : S_RWAIT;
            end
            S_RWAIT: begin
                if (abort) begin
                    state_d = S_FIN;
                end else if (rd_valid) begin
                    state_d = S_FIRE;
                end else begin
                    state_d = S_RWAIT;
                end
            end
            S_FIRE: begin
                tmo_d   = TMO_W'(TIMEOUT);
                state_d = abort ? S_FIN : S_MWAIT;
            end
            S_MWAIT: begin
                if (abort) begin
                    state_d = S_FIN;
                end else if (mmu_done) begin
                    state_d = S_WR;
                end else begin
                    tmo_d = tmo_dec_s;
                    // The TIMEOUT-th silent cycle ends the command with error
                    if (tmo_dec_s == {TMO_W{1'b0}}) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        state_d = S_MWAIT;
                    end
                end
            end
            S_WR: begin
                if (abort) begin
                    // Pending write is dropped and not counted
                    state_d = S_FIN;
                end else if (wr_ready) begin
                    rows_d  = rows_inc_s;
                    state_d = (rows_inc_s == num_q) ? S_FIN : S_RD;
                end else begin
                    state_d = S_WR;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, command context and registered outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= S_IDLE;
            src_q              <= {ADDR_W{1'b0}};
            dst_q              <= {ADDR_W{1'b0}};
            num_q              <= {CNT_W{1'b0}};
            rows_q             <= {CNT_W{1'b0}};
            tmo_q              <= {TMO_W{1'b0}};
            err_q              <= 1'b0;
            cmd_ready_q        <= 1'b1;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            mmu_clear_q        <= 1'b0;
            wt_load_req_q      <= 1'b0;
            rd_req_q           <= 1'b0;
            rd_addr_q          <= {ADDR_W{1'b0}};
            mmu_start_q        <= 1'b0;
            mmu_weight_valid_q <= 1'b0;
            wr_valid_q         <= 1'b0;
            wr_addr_q          <= {ADDR_W{1'b0}};
        end else begin
            state_q            <= state_d;
            src_q              <= src_d;
            dst_q              <= dst_d;
            num_q              <= num_d;
            rows_q             <= rows_d;
            tmo_q              <= tmo_d;
            err_q              <= err_d;
            cmd_ready_q        <= (state_d == S_IDLE);
            busy_q             <= (state_d != S_IDLE);
            done_q             <= (state_d == S_FIN);
            mmu_clear_q        <= clear_d;
            wt_load_req_q      <= (state_d == S_WLOAD);
            rd_req_q           <= (state_d == S_RD);
            rd_addr_q          <= (state_d == S_RD) ? rd_addr_s : {ADDR_W{1'b0}};
            mmu_start_q        <= (state_d == S_FIRE);
            // Weights stay valid from the load acknowledge until the command ends
            mmu_weight_valid_q <= (state_d inside {S_RD, S_RWAIT, S_FIRE, S_MWAIT, S_WR});
            wr_valid_q         <= (state_d == S_WR);
            wr_addr_q          <= (state_d == S_WR) ? wr_addr_s : {ADDR_W{1'b0}};
        end
    end

    assign cmd_ready        = cmd_ready_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = err_q;
    assign rows_done        = rows_q;
    assign mmu_clear        = mmu_clear_q;
    assign wt_load_req      = wt_load_req_q;
    assign rd_req           = rd_req_q;
    assign rd_addr          = rd_addr_q;
    assign mmu_start        = mmu_start_q;
    assign mmu_input_valid  = mmu_start_q;
    assign mmu_weight_valid = mmu_weight_valid_q;
    assign wr_valid         = wr_valid_q;
    assign wr_addr          = wr_addr_q;

endmodule

// File: tb/tb_mmu_row_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for mmu_row_sequencer. A cycle-stepped responder plays the weight
// loader, row buffer, MMU and result buffer; each scenario task compares the
// observed transactions against addresses and counts derived from the command.
// -----------------------------------------------------------------------------
module tb_mmu_row_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [9:0] cmd_src_base, cmd_dst_base;
    logic [7:0] cmd_num_rows;
    logic       abort, wt_load_req, wt_load_ack, rd_req, rd_valid;
    logic [9:0] rd_addr, wr_addr;
    logic       mmu_clear, mmu_start, mmu_input_valid, mmu_weight_valid, mmu_done;
    logic       wr_valid, wr_ready, busy, done, error;
    logic [7:0] rows_done;

    always #5 clk = ~clk;

    mmu_row_sequencer #(.ADDR_W(10), .CNT_W(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src_base(cmd_src_base), .cmd_dst_base(cmd_dst_base),
        .cmd_num_rows(cmd_num_rows), .abort(abort),
        .wt_load_req(wt_load_req), .wt_load_ack(wt_load_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .mmu_clear(mmu_clear), .mmu_start(mmu_start),
        .mmu_input_valid(mmu_input_valid), .mmu_weight_valid(mmu_weight_valid),
        .mmu_done(mmu_done), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_ready(wr_ready), .busy(busy), .done(done), .error(error),
        .rows_done(rows_done)
    );

    int checks = 0;
    int failures = 0;

    localparam logic [38:0] RESET_VEC = {1'b1, 38'd0};

    // scenario knobs
    logic [9:0] k_src, k_dst;
    logic [7:0] k_n;
    int  k_ack_dly, k_rd_dly, k_mmu_lat, k_stall0, k_abort_row;
    bit  k_mmu_never, k_rand_wr, k_rst_mwait;

    // observations of one command
    logic [9:0] obs_rd[$], obs_wr[$], obs_wv_addr[$];
    int  obs_rd_cyc[$], obs_hs_cyc[$];
    int  o_starts, o_dones, o_clears, o_wtreq, o_done_cyc, o_fire_cyc, o_abort_cyc, o_bad_wv;
    int  o_rows_at_done;
    logic o_err_at_done, o_err_c1, o_ready_after, o_busy_after;
    logic [38:0] o_snap;

    function automatic logic [38:0] outs_vec();
        return {cmd_ready, wt_load_req, rd_req, rd_addr, mmu_clear, mmu_start,
                mmu_input_valid, mmu_weight_valid, wr_valid, wr_addr, busy, done,
                error, rows_done};
    endfunction

    // Reference address of row i relative to a base, modulo the 1024-entry buffer
    function automatic logic [9:0] row_addr(logic [9:0] base, int i);
        return 10'((int'(base) + i) % 1024);
    endfunction

    task automatic set_defaults();
        k_ack_dly = 0; k_rd_dly = 1; k_mmu_lat = 1; k_stall0 = 0; k_abort_row = -1;
        k_mmu_never = 1'b0; k_rand_wr = 1'b0; k_rst_mwait = 1'b0;
    endtask

    // Issue one command and act as every responder until it finishes
    task automatic run_cmd();
        int cyc, wt_cnt, rd_cyc, fire_cyc, stall, hs_rows, post, end_cyc, rst_cyc;
        obs_rd.delete(); obs_wr.delete(); obs_wv_addr.delete();
        obs_rd_cyc.delete(); obs_hs_cyc.delete();
        o_starts = 0; o_dones = 0; o_clears = 0; o_wtreq = 0; o_done_cyc = -1;
        o_fire_cyc = -1; o_abort_cyc = -1; o_bad_wv = 0; o_rows_at_done = -1;
        o_err_at_done = 1'bx; o_err_c1 = 1'bx; o_ready_after = 1'bx; o_busy_after = 1'bx;
        o_snap = 39'd0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_src_base = k_src; cmd_dst_base = k_dst; cmd_num_rows = k_n;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_src_base = 10'($urandom); cmd_dst_base = 10'($urandom); cmd_num_rows = 8'($urandom);
        cyc = 1; wt_cnt = 0; rd_cyc = -100; fire_cyc = -100; stall = 0; hs_rows = 0;
        post = -1; end_cyc = 800; rst_cyc = -1;
        forever begin
            if (mmu_clear) o_clears++;
            if (cyc == 1) o_err_c1 = error;
            if (wt_load_req) begin o_wtreq++; wt_cnt++; end
            if (rd_req) begin obs_rd.push_back(rd_addr); obs_rd_cyc.push_back(cyc); rd_cyc = cyc; end
            if (mmu_start) begin
                o_starts++; fire_cyc = cyc;
                if (o_fire_cyc < 0) o_fire_cyc = cyc;
                if (!mmu_weight_valid || !mmu_input_valid) o_bad_wv++;
            end
            if (done) begin
                o_dones++; o_done_cyc = cyc; o_rows_at_done = int'(rows_done);
                o_err_at_done = error; post = cyc + 1; end_cyc = cyc + 1;
            end
            if (wr_valid) obs_wv_addr.push_back(wr_addr);
            if (cyc == post) begin o_ready_after = cmd_ready; o_busy_after = busy; end
            if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin o_snap = outs_vec(); rst = 1'b0; end
            if (cyc >= end_cyc) break;
            // responder drive for the next edge
            wt_load_ack = wt_load_req && (wt_cnt >= k_ack_dly);
            rd_valid = ((rd_cyc > fire_cyc) && (cyc - rd_cyc >= k_rd_dly)) ||
                       ((cyc == fire_cyc) && (fire_cyc > rd_cyc));
            mmu_done = !k_mmu_never && (fire_cyc > 0) && (cyc == fire_cyc + k_mmu_lat);
            if (wr_valid && hs_rows == 0 && stall < k_stall0) begin
                wr_ready = 1'b0; stall++;
            end else begin
                wr_ready = k_rand_wr ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            abort = (k_abort_row >= 0) && wr_valid && (hs_rows == k_abort_row) && (o_abort_cyc < 0);
            if (abort) begin wr_ready = 1'b1; o_abort_cyc = cyc; end
            if (wr_valid && wr_ready && !abort) begin
                obs_wr.push_back(wr_addr); obs_hs_cyc.push_back(cyc); hs_rows++;
            end
            if (k_rst_mwait && fire_cyc > 0 && cyc == fire_cyc + 1 && rst_cyc < 0) begin
                rst = 1'b1; rst_cyc = cyc; end_cyc = cyc + 6;
            end
            @(negedge clk);
            cyc++;
        end
        wt_load_ack = 1'b0; rd_valid = 1'b0; mmu_done = 1'b0; wr_ready = 1'b0;
        abort = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0; wt_load_ack = 1'b0; rd_valid = 1'b0;
        mmu_done = 1'b0; wr_ready = 1'b0;
        cmd_src_base = 10'd0; cmd_dst_base = 10'd0; cmd_num_rows = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (outs_vec() !== RESET_VEC) begin
            failures++; $display("FAIL reset_outputs got=%h exp=%h", outs_vec(), RESET_VEC);
        end
    endtask

    task automatic test_basic();
        set_defaults(); k_src = 10'h010; k_dst = 10'h200; k_n = 8'd3; k_ack_dly = 2;
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL basic_ready got=%b exp=1", cmd_ready); end
        run_cmd();
        checks++;
        if (obs_rd.size() != 3 || obs_wr.size() != 3) begin
            failures++; $display("FAIL basic_counts rd=%0d wr=%0d exp=3/3", obs_rd.size(), obs_wr.size());
        end
        for (int i = 0; i < 3; i++) begin
            logic [9:0] g_rd, g_wr;
            g_rd = (i < obs_rd.size()) ? obs_rd[i] : 10'bx;
            g_wr = (i < obs_wr.size()) ? obs_wr[i] : 10'bx;
            checks++;
            if (g_rd !== row_addr(k_src, i) || g_wr !== row_addr(k_dst, i)) begin
                failures++;
                $display("FAIL basic_addr row=%0d rd=%h wr=%h exp=%h/%h", i, g_rd, g_wr,
                         row_addr(k_src, i), row_addr(k_dst, i));
            end
        end
        checks++;
        if (o_starts != 3 || o_dones != 1 || o_clears != 1 || o_bad_wv != 0) begin
            failures++;
            $display("FAIL basic_pulses starts=%0d dones=%0d clears=%0d badwv=%0d exp=3/1/1/0",
                     o_starts, o_dones, o_clears, o_bad_wv);
        end
        checks++;
        if (o_rows_at_done != 3 || o_err_at_done !== 1'b0 || o_ready_after !== 1'b1 || o_busy_after !== 1'b0) begin
            failures++;
            $display("FAIL basic_status rows=%0d err=%b ready=%b busy=%b exp=3/0/1/0",
                     o_rows_at_done, o_err_at_done, o_ready_after, o_busy_after);
        end
    endtask

    task automatic test_zero_rows();
        set_defaults(); k_src = 10'h055; k_dst = 10'h0AA; k_n = 8'd0;
        run_cmd();
        checks++;
        if (o_clears != 1 || o_wtreq != 0 || o_starts != 0 || o_dones != 1) begin
            failures++;
            $display("FAIL zero_pulses clears=%0d wtreq=%0d starts=%0d dones=%0d exp=1/0/0/1",
                     o_clears, o_wtreq, o_starts, o_dones);
        end
        // accept cycle, then the finishing cycle carries done
        checks++;
        if (o_done_cyc != 1 || o_rows_at_done != 0) begin
            failures++; $display("FAIL zero_timing done_cyc=%0d rows=%0d exp=1/0", o_done_cyc, o_rows_at_done);
        end
    endtask

    task automatic test_backpressure();
        set_defaults(); k_src = 10'h010; k_dst = 10'h200; k_n = 8'd2; k_stall0 = 5;
        run_cmd();
        checks++;
        if (obs_wv_addr.size() != 7) begin
            failures++; $display("FAIL bp_valid_cycles got=%0d exp=7", obs_wv_addr.size());
        end
        for (int i = 0; i < 6; i++) begin
            logic [9:0] g;
            g = (i < obs_wv_addr.size()) ? obs_wv_addr[i] : 10'bx;
            checks++;
            if (g !== k_dst) begin failures++; $display("FAIL bp_addr_stable cyc=%0d got=%h exp=%h", i, g, k_dst); end
        end
        checks++;
        if (obs_rd_cyc.size() != 2 || obs_hs_cyc.size() != 2) begin
            failures++; $display("FAIL bp_counts rd=%0d hs=%0d exp=2/2", obs_rd_cyc.size(), obs_hs_cyc.size());
        end else if (obs_rd_cyc[1] <= obs_hs_cyc[0]) begin
            failures++; $display("FAIL bp_order rd1_cyc=%0d hs0_cyc=%0d exp rd1>hs0", obs_rd_cyc[1], obs_hs_cyc[0]);
        end
    endtask

    task automatic test_timeout();
        set_defaults(); k_src = 10'h100; k_dst = 10'h300; k_n = 8'd1; k_mmu_never = 1'b1;
        run_cmd();
        checks++;
        if (o_dones != 1 || o_done_cyc - o_fire_cyc != 17 || o_err_at_done !== 1'b1) begin
            failures++;
            $display("FAIL timeout_done dones=%0d delay=%0d err=%b exp=1/17/1",
                     o_dones, o_done_cyc - o_fire_cyc, o_err_at_done);
        end
        checks++;
        if (obs_wr.size() != 0 || o_rows_at_done != 0 || error !== 1'b1) begin
            failures++;
            $display("FAIL timeout_state wr=%0d rows=%0d err_after=%b exp=0/0/1", obs_wr.size(), o_rows_at_done, error);
        end
        set_defaults(); k_n = 8'd1;
        run_cmd();
        checks++;
        if (o_err_c1 !== 1'b0 || o_err_at_done !== 1'b0 || o_rows_at_done != 1) begin
            failures++;
            $display("FAIL timeout_clear err_c1=%b err_done=%b rows=%0d exp=0/0/1", o_err_c1, o_err_at_done, o_rows_at_done);
        end
    endtask

    task automatic test_abort();
        set_defaults(); k_src = 10'h020; k_dst = 10'h200; k_n = 8'd4; k_abort_row = 1;
        run_cmd();
        checks++;
        if (o_abort_cyc < 0 || o_done_cyc != o_abort_cyc + 1 || o_dones != 1) begin
            failures++;
            $display("FAIL abort_timing abort_cyc=%0d done_cyc=%0d dones=%0d exp done=abort+1",
                     o_abort_cyc, o_done_cyc, o_dones);
        end
        checks++;
        if (o_rows_at_done != 1 || obs_wr.size() != 1 || o_ready_after !== 1'b1 || o_busy_after !== 1'b0) begin
            failures++;
            $display("FAIL abort_state rows=%0d wr=%0d ready=%b busy=%b exp=1/1/1/0",
                     o_rows_at_done, obs_wr.size(), o_ready_after, o_busy_after);
        end
        // abort while idle changes nothing
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checks++;
        if ({cmd_ready, busy, done, wt_load_req} !== 4'b1000) begin
            failures++; $display("FAIL abort_idle got=%b exp=1000", {cmd_ready, busy, done, wt_load_req});
        end
    endtask

    task automatic test_wrap();
        set_defaults(); k_src = 10'h3FF; k_dst = 10'h3FE; k_n = 8'd2;
        run_cmd();
        checks++;
        if (obs_rd.size() != 2 || obs_wr.size() != 2) begin
            failures++; $display("FAIL wrap_counts rd=%0d wr=%0d exp=2/2", obs_rd.size(), obs_wr.size());
        end else if (obs_rd[0] !== 10'h3FF || obs_rd[1] !== 10'h000 || obs_wr[0] !== 10'h3FE || obs_wr[1] !== 10'h3FF) begin
            failures++;
            $display("FAIL wrap_addr rd=%h,%h wr=%h,%h exp=3ff,000 3fe,3ff", obs_rd[0], obs_rd[1], obs_wr[0], obs_wr[1]);
        end
    endtask

    task automatic test_reset_mwait();
        set_defaults(); k_src = 10'h040; k_dst = 10'h240; k_n = 8'd3;
        k_mmu_never = 1'b1; k_rst_mwait = 1'b1;
        run_cmd();
        checks++;
        if (o_snap !== RESET_VEC || o_dones != 0 || o_starts != 1) begin
            failures++;
            $display("FAIL reset_mwait snap=%h exp=%h dones=%0d starts=%0d exp=0/1", o_snap, RESET_VEC, o_dones, o_starts);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int n;
            set_defaults();
            n = int'($urandom_range(1, 6));
            k_n = 8'(n); k_src = 10'($urandom); k_dst = 10'($urandom);
            k_ack_dly = int'($urandom_range(0, 3)); k_rd_dly = int'($urandom_range(1, 3));
            k_mmu_lat = int'($urandom_range(1, 3)); k_rand_wr = 1'b1;
            run_cmd();
            checks++;
            if (obs_rd.size() != n || obs_wr.size() != n || o_starts != n || o_dones != 1) begin
                failures++;
                $display("FAIL rand_counts it=%0d rd=%0d wr=%0d starts=%0d dones=%0d exp n=%0d done=1",
                         it, obs_rd.size(), obs_wr.size(), o_starts, o_dones, n);
            end
            for (int i = 0; i < n; i++) begin
                logic [9:0] g_rd, g_wr;
                g_rd = (i < obs_rd.size()) ? obs_rd[i] : 10'bx;
                g_wr = (i < obs_wr.size()) ? obs_wr[i] : 10'bx;
                checks++;
                if (g_rd !== row_addr(k_src, i) || g_wr !== row_addr(k_dst, i)) begin
                    failures++;
                    $display("FAIL rand_addr it=%0d row=%0d rd=%h wr=%h exp=%h/%h", it, i, g_rd, g_wr,
                             row_addr(k_src, i), row_addr(k_dst, i));
                end
            end
            checks++;
            if (o_rows_at_done != n || o_err_at_done !== 1'b0 || o_bad_wv != 0 || o_ready_after !== 1'b1) begin
                failures++;
                $display("FAIL rand_status it=%0d rows=%0d err=%b badwv=%0d ready=%b exp=%0d/0/0/1",
                         it, o_rows_at_done, o_err_at_done, o_bad_wv, o_ready_after, n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_rows();
        test_backpressure();
        test_timeout();
        test_abort();
        test_wrap();
        test_reset_mwait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
